// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader
// Brief    : Burst read initiator for a registered-address single-port RAM,
//            delivering words on a valid/ready stream through a skid FIFO.
// Revision : 1.0
// ============================================================================
module ram_burst_reader #(
  parameter int AW         = 6,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   c_depth     = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] c_last_slot = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] c_ptr_one   = PW'(1);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [AW:0]   c_beat_one  = (AW+1)'(1);
  localparam logic [AW-1:0] c_addr_one  = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_issue_left;
  logic [AW:0]   r_beat_left;
  logic          r_inflight;
  logic          r_done;

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_accept;
  logic          w_last_pop;
  logic [CW:0]   w_occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_last_slot) ? '0 : p + c_ptr_one;
  endfunction

  assign w_pop      = m_valid & m_ready;
  assign w_push     = r_inflight;
  // Occupancy after this cycle's pop, counting the read still in the RAM pipe
  assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue    = (r_state == ISSUE) && (w_occ < c_depth);
  assign w_accept   = (r_state == IDLE) && start && (length != '0);
  assign w_last_pop = w_pop && (r_beat_left == c_beat_one);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (w_issue && (r_issue_left == c_beat_one)) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_pop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_beat_left  <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      r_done     <= (r_state == DRAIN) && w_last_pop;
      if (w_accept) begin
        r_addr       <= base_addr;
        r_issue_left <= length;
        r_beat_left  <= length;
      end else begin
        if (w_issue) begin
          r_addr       <= r_addr + c_addr_one;
          r_issue_left <= r_issue_left - c_beat_one;
        end
        if (w_pop) begin
          r_beat_left <= r_beat_left - c_beat_one;
        end
      end
    end
  end

  // Skid FIFO: the word read last cycle lands here unconditionally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= ram_rd_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign ram_rd_addr = r_addr;
  assign m_valid     = (r_count != '0);
  assign m_data      = r_mem[r_rd_ptr];
  assign m_last      = m_valid && (r_beat_left == c_beat_one);

endmodule
`default_nettype wire
